// File: rtl/sdr_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package sdr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests to start just above ptr,
// take the lowest set bit, then map it back to the real source index.
module rr_pick
  import sdr_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  int                 start;
  int                 win;
  logic               found;
  logic [NUM_SRC-1:0] rot;
  logic [SRC_W-1:0]   pos;

  always_comb begin
    start = (int'(ptr) + 1) % NUM_SRC;
    rot   = '0;
    pos   = '0;
    win   = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos    = SRC_W'((start + k) % NUM_SRC);
      rot[k] = req[pos];
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
    any = found;
    if (found) begin
      pos      = SRC_W'((start + win) % NUM_SRC);
      idx      = pos;
      gnt[pos] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port between
// NUM_SRC stream sources, with a registered output stage and source tagging.
module fifo_wr_arbiter
  import sdr_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int LOCK_PACKET = 1,
  parameter int SRC_W       = clog2_min1(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            in_valid,
  output logic [NUM_SRC-1:0]            in_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SRC-1:0]            in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
);

  arb_state_t             state_q, state_d;
  logic [NUM_SRC-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]       gidx_q, gidx_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [SRC_W-1:0]       out_src_q, out_src_d;

  logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];
  logic [NUM_SRC-1:0]     pick_gnt;
  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   ld;
  logic                   accept;
  logic                   sel_valid;
  logic                   sel_last;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
      assign src_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The output register can take a beat when empty or when drained this cycle.
  assign ld        = ~out_valid_q | out_ready;
  assign sel_valid = in_valid[gidx_q];
  assign sel_last  = in_last[gidx_q];
  assign accept    = (state_q == BUSY) & sel_valid & ld;

  assign in_ready  = ((state_q == BUSY) && ld) ? grant_q : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = src_data[gidx_q];
      out_last_d  = sel_last;
      out_src_d   = gidx_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Pointer only moves once the owner releases, so the winner is lowest next time.
        if (accept && (sel_last || (LOCK_PACKET == 0))) begin
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= SRC_W'(NUM_SRC - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and scoreboard bench: dut_a (4 src, locked), dut_b (4 src, per-beat),
// dut_c (3 src, locked, random traffic).
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    int         src;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic [3:0] v   [3];
  logic [3:0] lst [3];
  logic [7:0] dat [3][4];
  logic [3:0] en  [3];
  logic       ordy[3];
  bit   [3:0] hs  [3];
  logic [8:0] srcq[3][4][$];
  beat_t      blog[3][$];

  logic [3:0] rdy [3];
  logic       ov  [3];
  logic [7:0] od  [3];
  logic       ol  [3];
  logic [1:0] os  [3];
  logic [3:0] gr  [3];
  logic       bz  [3];

  wire [3:0] a_in_ready, b_in_ready, a_grant, b_grant;
  wire [2:0] c_in_ready, c_grant;
  wire       a_ov, b_ov, c_ov, a_ol, b_ol, c_ol, a_busy, b_busy, c_busy;
  wire [7:0] a_od, b_od, c_od;
  wire [1:0] a_os, b_os, c_os;

  always_comb begin
    rdy[0] = a_in_ready; rdy[1] = b_in_ready; rdy[2] = {1'b0, c_in_ready};
    ov[0]  = a_ov;       ov[1]  = b_ov;       ov[2]  = c_ov;
    od[0]  = a_od;       od[1]  = b_od;       od[2]  = c_od;
    ol[0]  = a_ol;       ol[1]  = b_ol;       ol[2]  = c_ol;
    os[0]  = a_os;       os[1]  = b_os;       os[2]  = c_os;
    gr[0]  = a_grant;    gr[1]  = b_grant;    gr[2]  = {1'b0, c_grant};
    bz[0]  = a_busy;     bz[1]  = b_busy;     bz[2]  = c_busy;
  end

  fifo_wr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .LOCK_PACKET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(a_in_ready),
    .in_data({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}), .in_last(lst[0]),
    .out_valid(a_ov), .out_ready(ordy[0]), .out_data(a_od), .out_last(a_ol),
    .out_src(a_os), .grant(a_grant), .busy(a_busy));

  fifo_wr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .LOCK_PACKET(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(b_in_ready),
    .in_data({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}), .in_last(lst[1]),
    .out_valid(b_ov), .out_ready(ordy[1]), .out_data(b_od), .out_last(b_ol),
    .out_src(b_os), .grant(b_grant), .busy(b_busy));

  fifo_wr_arbiter #(.NUM_SRC(3), .DATA_WIDTH(8), .LOCK_PACKET(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(v[2][2:0]), .in_ready(c_in_ready),
    .in_data({dat[2][2], dat[2][1], dat[2][0]}), .in_last(lst[2][2:0]),
    .out_valid(c_ov), .out_ready(ordy[2]), .out_data(c_od), .out_last(c_ol),
    .out_src(c_os), .grant(c_grant), .busy(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_drv();
    @(posedge clk); #1;
  endtask

  task automatic tick_smp();
    @(negedge clk); #3;
  endtask

  // Source model: present queue heads, pop on handshake; log every output transfer.
  initial begin
    for (int d = 0; d < 3; d++) begin
      v[d] = '0; lst[d] = '0; hs[d] = '0;
      for (int s = 0; s < 4; s++) dat[d][s] = '0;
    end
    forever begin
      @(negedge clk); #2;
      for (int d = 0; d < 3; d++) begin
        hs[d] = v[d] & rdy[d];
        if (ov[d] && ordy[d]) begin
          beat_t b;
          b.cyc = cyc; b.src = int'(os[d]); b.data = od[d]; b.last = ol[d];
          blog[d].push_back(b);
        end
      end
      @(posedge clk); #2;
      for (int d = 0; d < 3; d++) begin
        for (int s = 0; s < 4; s++) begin
          if (hs[d][s] && srcq[d][s].size() > 0) void'(srcq[d][s].pop_front());
          v[d][s]   = en[d][s] && (srcq[d][s].size() > 0);
          dat[d][s] = (srcq[d][s].size() > 0) ? srcq[d][s][0][7:0] : 8'h00;
          lst[d][s] = (srcq[d][s].size() > 0) ? srcq[d][s][0][8] : 1'b0;
        end
      end
    end
  end

  task automatic reset_all();
    tick_drv();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      for (int s = 0; s < 4; s++) srcq[d][s].delete();
      blog[d].delete();
      en[d]   = 4'hF;
      ordy[d] = 1'b1;
    end
    tick_drv();
    tick_drv();
  endtask

  task automatic release_rst();
    tick_drv();
    rst_n = 1'b1;
  endtask

  task automatic push_beat(input int d, input int s, input logic [7:0] data, input logic last);
    srcq[d][s].push_back({last, data});
  endtask

  task automatic push_pkt(input int d, input int s, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) push_beat(d, s, base + 8'(i), (i == n - 1));
  endtask

  task automatic wait_log(input string tag, input int d, input int n, input int budget);
    int k = 0;
    while (blog[d].size() < n && k < budget) begin
      tick_smp();
      k++;
    end
    check(tag, (blog[d].size() >= n), 1);
  endtask

  task automatic show(input string tag, input int d, input int i);
    $display("%s beat %0d: cyc=%0d src=%0d data=%02h last=%0b", tag, i,
             blog[d][i].cyc, blog[d][i].src, blog[d][i].data, blog[d][i].last);
  endtask

  initial begin
    int         k;
    int         e_src [8];
    logic [7:0] e_dat [8];
    logic [8:0] expq  [3][$];
    int         total, bad, dup, inter, open_src, cnt;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin en[d] = 4'hF; ordy[d] = 1'b1; end
    repeat (3) tick_drv();

    // Reset state
    reset_all();
    tick_smp();
    check("rst_out_valid", ov[0], 0);
    check("rst_out_data", od[0], 0);
    check("rst_out_last", ol[0], 0);
    check("rst_out_src", os[0], 0);
    check("rst_grant", gr[0], 0);
    check("rst_busy", bz[0], 0);
    check("rst_in_ready", rdy[0], 0);

    // Test 1: sources 0 and 2, 3-beat packets
    push_pkt(0, 0, 3, 8'h01);
    push_pkt(0, 2, 3, 8'h21);
    release_rst();
    wait_log("t1_done", 0, 6, 40);
    e_src = '{0, 0, 0, 2, 2, 2, 0, 0};
    e_dat = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23, 8'h00, 8'h00};
    for (int i = 0; i < 6 && i < blog[0].size(); i++) begin
      show("t1", 0, i);
      check("t1_src", blog[0][i].src, e_src[i]);
      check("t1_data", blog[0][i].data, e_dat[i]);
      check("t1_last", blog[0][i].last, (i == 2 || i == 5));
    end
    if (blog[0].size() >= 6) begin
      check("t1_b2b", blog[0][1].cyc - blog[0][0].cyc, 1);
      check("t1_gap", blog[0][3].cyc - blog[0][2].cyc, 2);
    end

    // Test 2: all four sources, single-beat packets
    reset_all();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++) push_pkt(0, s, 1, 8'(s * 16 + r));
    release_rst();
    wait_log("t2_done", 0, 8, 60);
    for (int i = 0; i < 8 && i < blog[0].size(); i++) begin
      show("t2", 0, i);
      check("t2_src", blog[0][i].src, i % 4);
      check("t2_data", blog[0][i].data, (i % 4) * 16 + i / 4);
      if (i > 0) check("t2_spacing", blog[0][i].cyc - blog[0][i-1].cyc, 2);
    end

    // Test 3: FIFO full while 0xA5 is held
    reset_all();
    push_beat(0, 1, 8'h11, 1'b0);
    push_beat(0, 1, 8'hA5, 1'b0);
    push_beat(0, 1, 8'h13, 1'b1);
    release_rst();
    k = 0;
    do begin tick_drv(); k++; end while (!(ov[0] && od[0] == 8'hA5) && k < 40);
    check("t3_reach_a5", (ov[0] && od[0] == 8'hA5), 1);
    ordy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_smp();
      check("t3_hold_valid", ov[0], 1);
      check("t3_hold_data", od[0], 8'hA5);
      check("t3_stall_ready", rdy[0], 0);
    end
    tick_drv();
    ordy[0] = 1'b1;
    wait_log("t3_done", 0, 3, 20);
    repeat (4) tick_smp();
    check("t3_count", blog[0].size(), 3);
    cnt = 0;
    for (int i = 0; i < blog[0].size(); i++) begin
      show("t3", 0, i);
      if (blog[0][i].data == 8'hA5) cnt++;
    end
    check("t3_a5_once", cnt, 1);
    if (blog[0].size() >= 3) check("t3_tail", blog[0][2].data, 8'h13);

    // Test 4: locked packet with owner valid gap, src3 waiting
    reset_all();
    push_pkt(0, 1, 4, 8'h50);
    push_pkt(0, 3, 1, 8'h70);
    release_rst();
    k = 0;
    do begin tick_smp(); k++; end while (!hs[0][1] && k < 40);
    check("t4_first_accept", hs[0][1], 1);
    en[0][1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_smp();
      check("t4_gap_grant", gr[0], 4'b0010);
      check("t4_gap_busy", bz[0], 1);
      check("t4_gap_ready", rdy[0], 4'b0010);
    end
    en[0][1] = 1'b1;
    wait_log("t4_done", 0, 5, 60);
    for (int i = 0; i < 5 && i < blog[0].size(); i++) begin
      show("t4", 0, i);
      check("t4_src", blog[0][i].src, (i < 4) ? 1 : 3);
    end
    if (blog[0].size() >= 4) check("t4_last", blog[0][3].last, 1);

    // Test 4b: per-beat arbitration alternates owners
    reset_all();
    push_pkt(1, 1, 4, 8'h80);
    push_pkt(1, 3, 4, 8'h90);
    release_rst();
    wait_log("t4b_done", 1, 8, 80);
    for (int i = 0; i < 8 && i < blog[1].size(); i++) begin
      show("t4b", 1, i);
      check("t4b_src", blog[1][i].src, (i % 2 == 0) ? 1 : 3);
      check("t4b_data", blog[1][i].data, ((i % 2 == 0) ? 8'h80 : 8'h90) + 8'(i / 2));
    end

    // Test 5: asynchronous reset mid-packet
    reset_all();
    push_pkt(0, 2, 3, 8'hC0);
    release_rst();
    k = 0;
    do begin tick_drv(); k++; end while (!ov[0] && k < 40);
    check("t5_in_packet", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", ov[0], 0);
    check("t5_async_grant", gr[0], 0);
    check("t5_async_busy", bz[0], 0);
    check("t5_async_ready", rdy[0], 0);
    reset_all();
    push_pkt(0, 3, 1, 8'hE3);
    push_pkt(0, 0, 1, 8'hE0);
    release_rst();
    wait_log("t5_done", 0, 2, 20);
    for (int i = 0; i < 2 && i < blog[0].size(); i++) begin
      show("t5", 0, i);
      check("t5_src", blog[0][i].src, (i == 0) ? 0 : 3);
    end

    // Test 6: random scoreboard on the 3-source instance
    reset_all();
    total = 0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 300; i++) begin
        logic [8:0] w;
        w = {($urandom_range(0, 3) == 0) || (i == 299), 2'(s), 6'(i)};
        srcq[2][s].push_back(w);
        expq[s].push_back(w);
        total++;
      end
    end
    release_rst();
    for (int c = 0; c < 10000; c++) begin
      tick_drv();
      en[2]   = 4'($urandom);
      ordy[2] = ($urandom_range(0, 3) != 0);
    end
    tick_drv();
    en[2]   = 4'hF;
    ordy[2] = 1'b1;
    wait_log("t6_drain", 2, total, 20000);
    bad = 0; dup = 0; inter = 0; open_src = -1;
    for (int i = 0; i < blog[2].size(); i++) begin
      int s;
      s = blog[2][i].src;
      show("t6", 2, i);
      if (s > 2 || expq[s].size() == 0) dup++;
      else if (expq[s].pop_front() !== {blog[2][i].last, blog[2][i].data}) bad++;
      if (open_src != -1 && s != open_src) inter++;
      open_src = blog[2][i].last ? -1 : s;
    end
    check("t6_order", bad, 0);
    check("t6_dup", dup, 0);
    check("t6_interleave", inter, 0);
    check("t6_count", blog[2].size(), total);
    check("t6_lost", expq[0].size() + expq[1].size() + expq[2].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
